// File: rtl/audio_sample_fifo_if.sv
// Register-bus bundle for the audio sample FIFO: one request/ready handshake,
// a 4-bit register offset, byte strobes (all zero for a read) and 32-bit data.
interface audio_sample_fifo_if;
    logic        sel;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel, valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  sel, valid, wstrb, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Bus-fed 12-bit sample FIFO that pops one sample per divider tick toward a
// PDM DAC, with sticky under/overflow flags and a low-water interrupt.
module audio_sample_fifo #(
    parameter int DEPTH       = 16,   // power of two, 4..32
    parameter int DIV_DEFAULT = 1999
) (
    input  logic                 CLK,
    input  logic                 resetn,
    audio_sample_fifo_if.slave   bus,
    output logic [11:0]          sample,
    output logic                 irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DIV    = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr, wptr_n, rptr_n;
    logic [LW-1:0] level, level_n;
    logic          enable, enable_n;
    logic [5:0]    thresh, thresh_n;
    logic [15:0]   div, div_n, cnt, cnt_n;
    logic          underflow, underflow_n, overflow, overflow_n;
    logic          irq_n;

    logic accept, rd, wr;
    logic wr_data, wr_status, wr_div, wr_ctrl;
    logic flush, tick, empty, full, pop, push, push_drop;
    logic [31:0] rd_mux;

    // Upper data bits carry no register field.
    logic unused_ok;
    assign unused_ok = ^bus.wdata[31:16];

    // A new transfer is taken only while ready is low, so a held request
    // completes on alternate cycles and each write acts exactly once.
    assign accept    = bus.sel && bus.valid && !bus.ready;
    assign wr        = accept && (|bus.wstrb);
    assign rd        = accept && !(|bus.wstrb);
    assign wr_data   = wr && (bus.addr == ADDR_DATA);
    assign wr_status = wr && (bus.addr == ADDR_STATUS);
    assign wr_div    = wr && (bus.addr == ADDR_DIV);
    assign wr_ctrl   = wr && (bus.addr == ADDR_CTRL);
    assign flush     = wr_ctrl && bus.wdata[1];

    assign tick  = enable && (cnt == 16'd0);
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // When full, the coincident pop frees the slot the push then takes.
    assign pop       = tick && !empty && !flush;
    assign push      = wr_data && (!full || pop);
    assign push_drop = wr_data && full && !pop;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case leaves it unassigned and infers a latch.
    always_comb begin
        wptr_n  = wptr;
        rptr_n  = rptr;
        level_n = level;
        if (flush) begin
            wptr_n  = '0;
            rptr_n  = '0;
            level_n = '0;
        end else begin
            if (push) wptr_n = wptr + AW'(1);
            if (pop)  rptr_n = rptr + AW'(1);
            level_n = level + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        enable_n = enable;
        thresh_n = thresh;
        div_n    = div;
        if (wr_ctrl) begin
            enable_n = bus.wdata[0];
            thresh_n = bus.wdata[13:8];
        end
        if (wr_div) div_n = bus.wdata[15:0];
    end

    // A DIV write restarts the period from the new value; disabled holds at DIV.
    always_comb begin
        cnt_n = cnt;
        if (wr_div)
            cnt_n = bus.wdata[15:0];
        else if (!enable || cnt == 16'd0)
            cnt_n = div;
        else
            cnt_n = cnt - 16'd1;
    end

    // Setting wins over a same-edge clear so no event is lost.
    always_comb begin
        underflow_n = (underflow && !(wr_status && bus.wdata[10])) || (tick && empty);
        overflow_n  = (overflow  && !(wr_status && bus.wdata[11])) || push_drop;
        irq_n       = enable_n && (6'(level_n) <= thresh_n);
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_STATUS: rd_mux = {20'd0, overflow, underflow, full, empty, 2'b00, 6'(level)};
            ADDR_DIV:    rd_mux = {16'd0, div};
            ADDR_CTRL:   rd_mux = {18'd0, thresh, 6'd0, 1'b0, enable};
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            sample    <= 12'h800;
            irq       <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            enable    <= 1'b0;
            thresh    <= '0;
            div       <= 16'(DIV_DEFAULT);
            cnt       <= 16'(DIV_DEFAULT);
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            bus.ready <= accept;
            if (accept) bus.rdata <= rd ? rd_mux : 32'd0;
            if (pop)    sample    <= mem[rptr];
            irq       <= irq_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            level     <= level_n;
            enable    <= enable_n;
            thresh    <= thresh_n;
            div       <= div_n;
            cnt       <= cnt_n;
            underflow <= underflow_n;
            overflow  <= overflow_n;
        end
    end

    // NOTE: the sample store is deliberately not reset; level and pointers
    // gate every read, and a reset-free array maps onto RAM.
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= bus.wdata[11:0];
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: register access, tick-paced playback,
// full/empty corner cases, low-water irq, back-to-back bus and reset abort.
module tb_audio_sample_fifo;

    localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] sample;
    logic        irq;

    audio_sample_fifo_if bus ();

    audio_sample_fifo #(.DEPTH(16), .DIV_DEFAULT(1999)) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus),
        .sample (sample),
        .irq    (irq)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Log every sample change with the cycle number of the edge that made it.
    int          cyc = 0;
    logic [11:0] last_sample = 12'h800;
    int          chg_cyc[$];
    logic [11:0] chg_val[$];

    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        if (sample !== last_sample) begin
            chg_cyc.push_back(cyc);
            chg_val.push_back(sample);
            last_sample = sample;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] r);
        @(negedge CLK);
        bus.sel   = 1'b1;
        bus.valid = 1'b1;
        bus.addr  = a;
        bus.wstrb = s;
        bus.wdata = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            if (bus.ready) break;
        end
        check("xfer_ready", 32'(bus.ready), 32'd1);
        r         = bus.rdata;
        bus.sel   = 1'b0;
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(a, 4'hF, d, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(a, 4'h0, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic clear_log();
        chg_cyc.delete();
        chg_val.delete();
    endtask

    initial begin
        logic [5:0] pat;
        bus.sel = 1'b0; bus.valid = 1'b0; bus.wstrb = 4'h0; bus.addr = 4'h0; bus.wdata = '0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready",  32'(bus.ready), 32'd0);
        check("rst_rdata",  bus.rdata,      32'd0);
        check("rst_sample", 32'(sample),    32'h800);
        check("rst_irq",    32'(irq),       32'd0);
        @(negedge CLK);
        resetn = 1'b1;

        rd_check("status_rst", A_STATUS, 32'h100);
        rd_check("div_rst",    A_DIV,    32'd1999);
        rd_check("ctrl_rst",   A_CTRL,   32'd0);
        rd_check("data_read",  A_DATA,   32'd0);
        wr(4'h2, 32'hFFFF_FFFF);
        rd_check("unmapped",   4'h2,     32'd0);
        rd_check("div_kept",   A_DIV,    32'd1999);

        // Playback at DIV=3: four-clock spacing, then underflow on empty tick
        wr(A_DIV, 32'd3);
        rd_check("div_rb", A_DIV, 32'd3);
        wr(A_DATA, 32'h111);
        wr(A_DATA, 32'h222);
        wr(A_DATA, 32'h333);
        rd_check("status_3", A_STATUS, 32'h003);
        clear_log();
        wr(A_CTRL, 32'h1);
        repeat (20) @(negedge CLK);
        check("play_n", 32'(chg_val.size()), 32'd3);
        if (chg_val.size() == 3) begin
            check("play_v0", 32'(chg_val[0]), 32'h111);
            check("play_v1", 32'(chg_val[1]), 32'h222);
            check("play_v2", 32'(chg_val[2]), 32'h333);
            check("play_gap1", 32'(chg_cyc[1] - chg_cyc[0]), 32'd4);
            check("play_gap2", 32'(chg_cyc[2] - chg_cyc[1]), 32'd4);
        end
        rd_check("status_udf", A_STATUS, 32'h500);
        check("udf_hold", 32'(sample), 32'h333);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'hC00);
        rd_check("sticky_clr", A_STATUS, 32'h100);

        // Overfill: 17th push dropped and never played
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'hA00 + 32'(i));
        rd_check("status_ovf", A_STATUS, 32'hA10);
        clear_log();
        wr(A_CTRL, 32'h1);
        repeat (80) @(negedge CLK);
        wr(A_CTRL, 32'h0);
        check("ovf_n", 32'(chg_val.size()), 32'd16);
        if (chg_val.size() == 16) begin
            check("ovf_first", 32'(chg_val[0]),  32'hA00);
            check("ovf_last",  32'(chg_val[15]), 32'hA0F);
        end
        wr(A_STATUS, 32'hC00);

        // Full FIFO: push lands on the same edge as a tick
        for (int i = 0; i < 16; i++) wr(A_DATA, 32'hB00 + 32'(i));
        rd_check("status_full", A_STATUS, 32'h210);
        clear_log();
        wr(A_CTRL, 32'h1);          // tick fires 4 edges after this accept
        repeat (3) @(posedge CLK);
        wr(A_DATA, 32'hBAA);        // accepted on that 4th edge
        rd_check("full_pushpop", A_STATUS, 32'h210);
        check("full_pop_head", 32'(sample), 32'hB00);
        repeat (90) @(negedge CLK);
        wr(A_CTRL, 32'h0);
        check("full_n", 32'(chg_val.size()), 32'd17);
        if (chg_val.size() == 17)
            check("full_last", 32'(chg_val[16]), 32'hBAA);
        wr(A_STATUS, 32'hC00);

        // Low-water irq and flush
        wr(A_DIV, 32'd40);
        wr(A_DATA, 32'hC01);
        wr(A_DATA, 32'hC02);
        wr(A_DATA, 32'hC03);
        wr(A_CTRL, 32'h201);
        check("irq_lvl3", 32'(irq), 32'd0);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (sample == 12'hC01) break;
        end
        check("lw_pop", 32'(sample), 32'hC01);
        check("irq_lvl2", 32'(irq), 32'd1);
        wr(A_CTRL, 32'h203);
        rd_check("flush_status", A_STATUS, 32'h100);
        check("flush_irq", 32'(irq), 32'd1);
        check("flush_sample", 32'(sample), 32'hC01);
        rd_check("ctrl_rb", A_CTRL, 32'h201);
        wr(A_CTRL, 32'h200);
        check("irq_disabled", 32'(irq), 32'd0);

        // Valid held high: ready on alternate cycles, one push each
        repeat (2) @(negedge CLK);
        bus.sel = 1'b1; bus.valid = 1'b1; bus.addr = A_DATA; bus.wstrb = 4'hF; bus.wdata = 32'hD55;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            pat[i] = bus.ready;
        end
        bus.sel = 1'b0; bus.valid = 1'b0; bus.wstrb = 4'h0;
        check("b2b_ready", 32'(pat), 32'h15);
        rd_check("b2b_level", A_STATUS, 32'h003);

        // Reset mid-period and mid-transfer: no late ready, state back to reset
        wr(A_DIV, 32'd3);
        wr(A_CTRL, 32'h1);
        @(negedge CLK);
        bus.sel = 1'b1; bus.valid = 1'b1; bus.addr = A_STATUS; bus.wstrb = 4'h0;
        resetn = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_ready_in", 32'(bus.ready), 32'd0);
        @(negedge CLK);
        bus.sel = 1'b0; bus.valid = 1'b0;
        resetn = 1'b1;
        pat = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            pat[i] = bus.ready;
        end
        check("abort_no_ready", 32'(pat), 32'd0);
        check("abort_sample", 32'(sample), 32'h800);
        check("abort_irq", 32'(irq), 32'd0);
        rd_check("abort_status", A_STATUS, 32'h100);
        rd_check("abort_ctrl",   A_CTRL,   32'd0);
        rd_check("abort_div",    A_DIV,    32'd1999);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
